// File: rtl/vend_pkg.sv
// Shared types and coin constants for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_10 = 10;
  localparam int unsigned COIN_20 = 20;

  function automatic logic coin_legal(input logic [31:0] value);
    return (value == COIN_5) || (value == COIN_10) || (value == COIN_20);
  endfunction

endpackage

// File: rtl/vend_price_mux.sv
// Picks price and stock flag of the selected product; out-of-range ids read as sold out.
// Purely combinational.
module vend_price_mux #(
  parameter int N_PRODUCTS = 4,
  parameter int CREDIT_W   = 8
) (
  input  logic [N_PRODUCTS*CREDIT_W-1:0]  price,
  input  logic [N_PRODUCTS-1:0]           sold_out,
  input  logic [$clog2(N_PRODUCTS)-1:0]   sel_id,
  output logic [CREDIT_W-1:0]             sel_price,
  output logic                            sel_bad
);

  always_comb begin
    sel_price = '0;
    sel_bad   = 1'b1;
    for (int i = 0; i < N_PRODUCTS; i++) begin
      if (32'(sel_id) == 32'(i)) begin
        sel_price = price[i*CREDIT_W +: CREDIT_W];
        sel_bad   = sold_out[i];
      end
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, selection check, dispense and change handshakes.
// Optional idle auto-refund from CREDIT is built when VEND_TIMEOUT_EN is defined.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int N_PRODUCTS  = 4,
  parameter int CREDIT_W    = 8,
  parameter int COIN_W      = 5,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            coin_valid,
  input  logic [COIN_W-1:0]               coin_value,
  output logic                            coin_reject,
  input  logic                            sel_valid,
  input  logic [$clog2(N_PRODUCTS)-1:0]   sel_id,
  input  logic                            cancel,
  input  logic [N_PRODUCTS*CREDIT_W-1:0]  price,
  input  logic [N_PRODUCTS-1:0]           sold_out,
  output logic                            dispense_valid,
  input  logic                            dispense_ready,
  output logic [$clog2(N_PRODUCTS)-1:0]   dispense_id,
  output logic                            change_valid,
  input  logic                            change_ready,
  output logic [CREDIT_W-1:0]             change_amount,
  output logic [CREDIT_W-1:0]             credit,
  output logic                            busy,
  output logic                            err_insufficient,
  output logic                            err_sold_out
);

  if (N_PRODUCTS < 2 || N_PRODUCTS > 16 || TIMEOUT_CYC < 1 || COIN_W > CREDIT_W) begin : g_param_check
    $error("vend_ctrl: parameter out of range");
  end

  state_t state;

  logic [CREDIT_W-1:0] sel_price;
  logic                sel_bad;
  logic                insufficient;
  logic                sel_ok;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                cancel_eff;

  vend_price_mux #(
    .N_PRODUCTS (N_PRODUCTS),
    .CREDIT_W   (CREDIT_W)
  ) u_price_mux (
    .price     (price),
    .sold_out  (sold_out),
    .sel_id    (sel_id),
    .sel_price (sel_price),
    .sel_bad   (sel_bad)
  );

  // Extra carry bit catches credit overflow before it wraps.
  assign coin_sum     = {1'b0, credit} + (CREDIT_W+1)'(coin_value);
  assign coin_ok      = coin_legal(32'(coin_value)) && !coin_sum[CREDIT_W];
  assign insufficient = credit < sel_price;
  assign sel_ok       = sel_valid && !sel_bad && !insufficient;

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  assign timeout    = (state == CREDIT) && (to_cnt == TO_W'(TIMEOUT_CYC - 1))
                      && !(coin_valid && coin_ok);
  assign cancel_eff = cancel || timeout;

  always_ff @(posedge clock) begin
    if (reset || state != CREDIT || (coin_valid && coin_ok)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign cancel_eff = cancel;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      credit           <= '0;
      coin_reject      <= 1'b0;
      dispense_valid   <= 1'b0;
      dispense_id      <= '0;
      change_valid     <= 1'b0;
      change_amount    <= '0;
      busy             <= 1'b0;
      err_insufficient <= 1'b0;
      err_sold_out     <= 1'b0;
    end else begin
      coin_reject      <= 1'b0;
      err_insufficient <= 1'b0;
      err_sold_out     <= 1'b0;
      case (state)
        IDLE, CREDIT: begin
          if (state == CREDIT && cancel_eff) begin
            state         <= CHANGE;
            change_valid  <= 1'b1;
            change_amount <= credit;
            busy          <= 1'b1;
            coin_reject   <= coin_valid;
          end else if (sel_ok) begin
            state          <= VEND;
            dispense_valid <= 1'b1;
            dispense_id    <= sel_id;
            credit         <= credit - sel_price;
            busy           <= 1'b1;
            coin_reject    <= coin_valid;
          end else begin
            // A failed selection still lets a same-cycle coin through.
            err_sold_out     <= sel_valid && sel_bad;
            err_insufficient <= sel_valid && !sel_bad && insufficient;
            if (coin_valid) begin
              if (coin_ok) begin
                credit <= coin_sum[CREDIT_W-1:0];
                state  <= CREDIT;
              end else begin
                coin_reject <= 1'b1;
              end
            end
          end
        end
        VEND: begin
          coin_reject <= coin_valid;
          if (dispense_ready) begin
            dispense_valid <= 1'b0;
            if (credit != '0) begin
              state         <= CHANGE;
              change_valid  <= 1'b1;
              change_amount <= credit;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          if (change_ready) begin
            change_valid  <= 1'b0;
            change_amount <= '0;
            credit        <= '0;
            state         <= IDLE;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl; auto-refund scenario runs when VEND_TIMEOUT_EN is defined.
module tb_vend_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        coin_valid;
  logic [4:0]  coin_value;
  logic        coin_reject;
  logic        sel_valid;
  logic [1:0]  sel_id;
  logic        cancel;
  logic [31:0] price;
  logic [3:0]  sold_out;
  logic        dispense_valid;
  logic        dispense_ready;
  logic [1:0]  dispense_id;
  logic        change_valid;
  logic        change_ready;
  logic [7:0]  change_amount;
  logic [7:0]  credit;
  logic        busy;
  logic        err_insufficient;
  logic        err_sold_out;

  int tests = 0;
  int fails = 0;

  vend_ctrl #(
    .N_PRODUCTS  (4),
    .CREDIT_W    (8),
    .COIN_W      (5),
    .TIMEOUT_CYC (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .coin_valid       (coin_valid),
    .coin_value       (coin_value),
    .coin_reject      (coin_reject),
    .sel_valid        (sel_valid),
    .sel_id           (sel_id),
    .cancel           (cancel),
    .price            (price),
    .sold_out         (sold_out),
    .dispense_valid   (dispense_valid),
    .dispense_ready   (dispense_ready),
    .dispense_id      (dispense_id),
    .change_valid     (change_valid),
    .change_ready     (change_ready),
    .change_amount    (change_amount),
    .credit           (credit),
    .busy             (busy),
    .err_insufficient (err_insufficient),
    .err_sold_out     (err_sold_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put_coin(input logic [4:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1;
    sel_id    = id;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++;
    if (credit !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state credit=%0d busy=%0b required credit=0 busy=0", credit, busy);
    end
    tests++;
    if ({dispense_valid, change_valid, coin_reject, err_insufficient, err_sold_out} !== 5'b0
        || dispense_id !== 2'd0 || change_amount !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs dv=%0b cv=%0b rej=%0b ei=%0b es=%0b id=%0d amt=%0d required all 0",
               dispense_valid, change_valid, coin_reject, err_insufficient, err_sold_out,
               dispense_id, change_amount);
    end
  endtask

  task automatic test_change();
    put_coin(5'd10);
    put_coin(5'd10);
    tests++;
    if (credit !== 8'd20) begin
      fails++;
      $display("FAIL change_credit got=%0d required=20", credit);
    end
    select(2'd2);
    tests++;
    if (dispense_valid !== 1'b1 || dispense_id !== 2'd2 || credit !== 8'd5 || busy !== 1'b1) begin
      fails++;
      $display("FAIL change_dispense dv=%0b id=%0d credit=%0d busy=%0b required 1/2/5/1",
               dispense_valid, dispense_id, credit, busy);
    end
    tick();
    tests++;
    if (change_valid !== 1'b1 || change_amount !== 8'd5 || dispense_valid !== 1'b0) begin
      fails++;
      $display("FAIL change_amount cv=%0b amt=%0d dv=%0b required 1/5/0",
               change_valid, change_amount, dispense_valid);
    end
    tick();
    tests++;
    if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL change_idle cv=%0b credit=%0d busy=%0b required 0/0/0",
               change_valid, credit, busy);
    end
  endtask

  task automatic test_insufficient();
    put_coin(5'd5);
    select(2'd0);
    tests++;
    if (err_insufficient !== 1'b1 || credit !== 8'd5 || dispense_valid !== 1'b0) begin
      fails++;
      $display("FAIL insuff_err ei=%0b credit=%0d dv=%0b required 1/5/0",
               err_insufficient, credit, dispense_valid);
    end
    tick();
    tests++;
    if (err_insufficient !== 1'b0) begin
      fails++;
      $display("FAIL insuff_pulse_width ei=%0b required 0", err_insufficient);
    end
    put_coin(5'd5);
    select(2'd0);
    tests++;
    if (dispense_valid !== 1'b1 || dispense_id !== 2'd0 || credit !== 8'd0) begin
      fails++;
      $display("FAIL insuff_dispense dv=%0b id=%0d credit=%0d required 1/0/0",
               dispense_valid, dispense_id, credit);
    end
    tick();
    tests++;
    if (dispense_valid !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL insuff_no_change dv=%0b cv=%0b busy=%0b required 0/0/0",
               dispense_valid, change_valid, busy);
    end
  endtask

  task automatic test_sold_out();
    sold_out = 4'b0010;
    put_coin(5'd20);
    select(2'd1);
    tests++;
    if (err_sold_out !== 1'b1 || err_insufficient !== 1'b0 || credit !== 8'd20
        || dispense_valid !== 1'b0) begin
      fails++;
      $display("FAIL sold_out_err es=%0b ei=%0b credit=%0d dv=%0b required 1/0/20/0",
               err_sold_out, err_insufficient, credit, dispense_valid);
    end
    cancel     = 1'b1;
    coin_valid = 1'b1;
    coin_value = 5'd5;
    tick();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    tests++;
    if (change_valid !== 1'b1 || change_amount !== 8'd20 || coin_reject !== 1'b1) begin
      fails++;
      $display("FAIL cancel_refund cv=%0b amt=%0d rej=%0b required 1/20/1",
               change_valid, change_amount, coin_reject);
    end
    tick();
    sold_out = 4'b0000;
    tests++;
    if (change_valid !== 1'b0 || credit !== 8'd0) begin
      fails++;
      $display("FAIL cancel_idle cv=%0b credit=%0d required 0/0", change_valid, credit);
    end
  endtask

  task automatic test_coin_reject();
    put_coin(5'd7);
    tests++;
    if (coin_reject !== 1'b1 || credit !== 8'd0) begin
      fails++;
      $display("FAIL coin_illegal rej=%0b credit=%0d required 1/0", coin_reject, credit);
    end
    for (int i = 0; i < 12; i++) put_coin(5'd20);
    put_coin(5'd10);
    tests++;
    if (credit !== 8'd250 || coin_reject !== 1'b0) begin
      fails++;
      $display("FAIL coin_fill credit=%0d rej=%0b required 250/0", credit, coin_reject);
    end
    put_coin(5'd10);
    tests++;
    if (coin_reject !== 1'b1 || credit !== 8'd250) begin
      fails++;
      $display("FAIL coin_overflow rej=%0b credit=%0d required 1/250", coin_reject, credit);
    end
    put_coin(5'd5);
    tests++;
    if (coin_reject !== 1'b0 || credit !== 8'd255) begin
      fails++;
      $display("FAIL coin_max rej=%0b credit=%0d required 0/255", coin_reject, credit);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tests++;
    if (change_amount !== 8'd255 || change_valid !== 1'b1) begin
      fails++;
      $display("FAIL coin_max_refund amt=%0d cv=%0b required 255/1", change_amount, change_valid);
    end
    tick();
  endtask

  task automatic test_stall();
    dispense_ready = 1'b0;
    put_coin(5'd20);
    coin_valid = 1'b1;
    coin_value = 5'd5;
    select(2'd3);
    coin_valid = 1'b0;
    tests++;
    if (dispense_valid !== 1'b1 || dispense_id !== 2'd3 || coin_reject !== 1'b1 || credit !== 8'd0) begin
      fails++;
      $display("FAIL stall_start dv=%0b id=%0d rej=%0b credit=%0d required 1/3/1/0",
               dispense_valid, dispense_id, coin_reject, credit);
    end
    price[3*8 +: 8] = 8'd5;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        put_coin(5'd10);
        tests++;
        if (coin_reject !== 1'b1 || credit !== 8'd0) begin
          fails++;
          $display("FAIL stall_coin rej=%0b credit=%0d required 1/0", coin_reject, credit);
        end
      end else begin
        tick();
      end
      tests++;
      if (dispense_valid !== 1'b1 || dispense_id !== 2'd3 || busy !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold cycle=%0d dv=%0b id=%0d busy=%0b required 1/3/1",
                 i, dispense_valid, dispense_id, busy);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dispense_ready = 1'b1;
    price[3*8 +: 8] = 8'd20;
    tests++;
    if ({dispense_valid, change_valid, busy, coin_reject} !== 4'b0 || credit !== 8'd0
        || dispense_id !== 2'd0) begin
      fails++;
      $display("FAIL stall_reset dv=%0b cv=%0b busy=%0b rej=%0b credit=%0d id=%0d required all 0",
               dispense_valid, change_valid, busy, coin_reject, credit, dispense_id);
    end
  endtask

  task automatic test_timeout();
    change_ready = 1'b0;
    put_coin(5'd10);
`ifdef VEND_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    tests++;
    if (change_valid !== 1'b0 || credit !== 8'd10) begin
      fails++;
      $display("FAIL timeout_early cv=%0b credit=%0d required 0/10", change_valid, credit);
    end
    tick();
    tests++;
    if (change_valid !== 1'b1 || change_amount !== 8'd10) begin
      fails++;
      $display("FAIL timeout_refund cv=%0b amt=%0d required 1/10", change_valid, change_amount);
    end
`else
    for (int i = 0; i < 20; i++) tick();
    tests++;
    if (change_valid !== 1'b0 || credit !== 8'd10) begin
      fails++;
      $display("FAIL credit_held cv=%0b credit=%0d required 0/10", change_valid, credit);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
`endif
    change_ready = 1'b1;
    tick();
    tests++;
    if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_idle cv=%0b credit=%0d busy=%0b required 0/0/0",
               change_valid, credit, busy);
    end
  endtask

  initial begin
    reset          = 1'b1;
    coin_valid     = 1'b0;
    coin_value     = '0;
    sel_valid      = 1'b0;
    sel_id         = '0;
    cancel         = 1'b0;
    price          = {8'd20, 8'd15, 8'd10, 8'd10};
    sold_out       = '0;
    dispense_ready = 1'b1;
    change_ready   = 1'b1;
    test_reset();
    test_change();
    test_insufficient();
    test_sold_out();
    test_coin_reject();
    test_stall();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised vending controller for the product-dispense subsystem, supporting N products with run-time prices and per-product sold-out flags. It accumulates coin credit, validates a selection against price and stock, and issues a dispense request with a ready/valid handshake. It then returns exact change, or the full credit on cancel, through a second handshake.

## Interface
- N_PRODUCTS, 4: number of selectable products (2..16).
- CREDIT_W, 8: credit, price and change width.
- COIN_W, 5: coin value width.
- TIMEOUT_CYC, 1000: idle cycles before auto-refund (VEND_TIMEOUT_EN only).
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- coin_valid  in  1  coin presented this cycle.
- coin_value  in  COIN_W  coin denomination.
- coin_reject  out  1  one-cycle pulse when the presented coin is refused.
- sel_valid  in  1  selection strobe.
- sel_id  in  $clog2(N_PRODUCTS)  selected product index.
- cancel  in  1  refund request.
- price  in  N_PRODUCTS*CREDIT_W  flat price vector; product i occupies bits [i*CREDIT_W +: CREDIT_W].
- sold_out  in  N_PRODUCTS  per-product empty flag.
- dispense_valid / dispense_ready  out / in  1  dispense handshake.
- dispense_id  out  $clog2(N_PRODUCTS)  product being dispensed.
- change_valid / change_ready  out / in  1  change handshake.
- change_amount  out  CREDIT_W  amount returned.
- credit  out  CREDIT_W  current accumulated credit.
- busy  out  1  high in VEND or CHANGE.
- err_insufficient, err_sold_out  out  1  one-cycle error pulses.

## Operation
- States: IDLE (credit=0), CREDIT, VEND, CHANGE.
- Accepted coins: 5, 10 and 20 only.
  - Any other value, or a coin that would overflow credit past 2^CREDIT_W-1, pulses coin_reject; credit is unchanged.
- An accepted coin adds to credit; IDLE→CREDIT.
- sel_valid in IDLE/CREDIT is evaluated in priority order:
  - sel_id ≥ N_PRODUCTS or sold_out[sel_id] set: err_sold_out pulse, state unchanged.
  - credit < price[sel_id]: err_insufficient pulse, state unchanged.
  - Otherwise: latch dispense_id, credit ← credit − price, go to VEND.
- VEND: dispense_valid high until dispense_ready. Then go to CHANGE if credit > 0, else IDLE.
- CHANGE: change_amount = credit, change_valid high until change_ready. Then credit ← 0, go to IDLE.
- cancel in CREDIT: go to CHANGE with the full credit. cancel in IDLE, VEND or CHANGE is ignored.
- Same-cycle priority: cancel > sel_valid > coin_valid.
  - A coin that loses to cancel or to a successful selection pulses coin_reject.
  - A coin that coincides with a failed selection is still accepted.
- In VEND and CHANGE, every coin is rejected and sel_valid is ignored.
- Price change during VEND does not affect the latched transaction.
- Price of 0 is legal: dispenses with no credit deducted.

## Timing
- Reset values: state IDLE, credit 0, every other output 0.
- Reset mid-transaction discards credit without returning change.
- Coin, selection and cancel are sampled on the rising edge. credit reflects an accepted coin on the following cycle.
- dispense_valid rises 1 cycle after a successful selection.
- The handshake completes on the edge where valid && ready; the next state is entered the following cycle.
- valid is never dropped before ready arrives; dispense_id and change_amount stay stable while valid is high.
- Error and reject pulses are exactly 1 cycle, coincident with the cycle after the sampled strobe.
- Minimum transaction (coin, select, ready=1 throughout): 4 cycles from coin to IDLE when change is due.

## Configuration
- VEND_TIMEOUT_EN defined:
  - A counter clears on every accepted coin and on entry to CREDIT.
  - After TIMEOUT_CYC consecutive cycles in CREDIT with no accepted coin, the block behaves as cancel (→CHANGE, full refund).
- Undefined: no counter is synthesised, credit is held indefinitely, and TIMEOUT_CYC is unused.

## Structure
- vend_pkg holds: state enum, coin constants COIN_5/10/20, and the coin_legal() function.
- Sub-module vend_price_mux: combinational selection of price[sel_id] and sold_out[sel_id] with range check. All sequential logic stays in vend_ctrl.

## Test plan
- Coins 10+10, price[2]=15, select 2, ready=1 → dispense_id=2; then change_amount=5; then IDLE, credit=0.
- Coin 5, select product priced 10 → err_insufficient pulse, credit stays 5; add coin 5, select again → dispense, no change phase.
- sold_out[1]=1, credit 20, select 1 → err_sold_out; cancel → change_amount=20.
- Coin 7 → coin_reject; credit 250 (CREDIT_W=8) plus coin 10 → coin_reject, credit stays 250.
- dispense_ready held low 5 cycles → dispense_valid and dispense_id stable; a coin during the stall is rejected; reset mid-VEND → all outputs 0 the next cycle.
- VEND_TIMEOUT_EN with TIMEOUT_CYC=8: coin 10, then idle 8 cycles → change_valid with amount 10.
